cva6_ras_circ: RTL
==================

CVA6_RAS_CIRC -- requirements
Module: cva6_ras_circ

Interface
REQ-001 SHALL have parameter XLEN, default 64: return-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 2: entry count; legal values are powers of two ≥ 2; other values SHALL fail elaboration.
REQ-003 SHALL have parameter CKPT_EN, default 1: 1 enables the checkpoint/restore ports; 0 ties their effect off.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 flush_i  in  1  empty the stack.
REQ-007 push_i  in  1  call detected; push push_addr_i.
REQ-008 push_addr_i  in  XLEN  return address to push.
REQ-009 pop_i  in  1  return detected; pop the top entry.
REQ-010 ckpt_save_i  in  1  snapshot top-of-stack pointer and count.
REQ-011 ckpt_restore_i  in  1  restore pointer and count from the snapshot (branch mispredict).
REQ-012 top_valid_o  out  1  stack non-empty.
REQ-013 top_addr_o  out  XLEN  address at top of stack; 0 when empty.
REQ-014 count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Storage SHALL be a circular array of DEPTH entries, a tos pointer of $clog2(DEPTH) bits, and an occupancy counter.
REQ-016 Outputs SHALL be driven from registered state only; an update is visible on the cycle after the causing edge.
REQ-017 Push only: tos SHALL increment modulo DEPTH; the entry at the new tos SHALL be written; count SHALL saturate at DEPTH, with the oldest entry overwritten on overflow.
REQ-018 Pop only, with count>0: tos SHALL decrement modulo DEPTH; count SHALL decrement; entry data SHALL be left unchanged.
REQ-019 Pop only, with count=0: the pop SHALL be ignored; tos and count SHALL be unchanged.
REQ-020 Push and pop in the same cycle: the entry at the current tos SHALL be overwritten with push_addr_i; tos SHALL be unchanged; count SHALL be unchanged. If count=0, the entry SHALL be written and count SHALL become 1.
REQ-021 ckpt_save_i SHALL capture the post-update values of tos and count for the same cycle.
REQ-022 ckpt_restore_i SHALL load the saved tos and count, and SHALL take priority over push, pop and save in the same cycle.
REQ-023 Entry contents SHALL NOT be restored; data overwritten after the save remains overwritten.
REQ-024 flush_i SHALL set count=0, tos=0 and the saved snapshot to 0, and SHALL take priority over restore, push and pop.
REQ-025 When CKPT_EN=0, ckpt_save_i and ckpt_restore_i SHALL have no effect.
REQ-026 top_addr_o SHALL equal the entry at tos when count>0, and 0 otherwise.

Reset
REQ-027 On rst_i=1 at a clock edge, tos, count and the snapshot SHALL be 0, and every entry SHALL be 0.
REQ-028 While rst_i=1, top_valid_o=0, top_addr_o=0 and count_o=0.
REQ-029 Reset SHALL override all inputs; an operation that coincides with reset SHALL be discarded.

Structure
REQ-030 Package ras_pkg SHALL hold the entry typedef ras_entry_t {logic [XLEN-1:0] ra} (parametrised via the cva6_cfg XLEN and RASDepth fields) and the snapshot typedef ras_ckpt_t {tos, count}.
REQ-031 The block SHALL be a single module with no sub-module; pointer arithmetic SHALL be inline, with wrap-around by natural overflow of the $clog2(DEPTH)-bit pointer.
REQ-032 DEPTH in the core SHALL be sourced from cva6_cfg.RASDepth.

Verification (DEPTH=4, XLEN=64)
REQ-033 Push 0x100, 0x200, 0x300, then pop three times -> top_addr_o reads 0x300, 0x200, 0x100, then top_valid_o=0 and count_o=0.
REQ-034 Push 0x10..0x50 (five pushes) -> count_o=4; four pops return 0x50, 0x40, 0x30, 0x20; the fifth pop is ignored and count_o stays 0.
REQ-035 Push 0xA0, then push and pop together with push_addr_i=0xB0 -> count_o=1 and top_addr_o=0xB0; the same on an empty stack -> count_o=1 and top_addr_o=0xB0.
REQ-036 Push 0x1 and 0x2, save, push 0x3, pop, pop, restore -> count_o=2 and top_addr_o=0x2; restore asserted together with push -> the push is discarded.
REQ-037 Flush asserted together with push 0x77 at count 3 -> next cycle count_o=0 and top_valid_o=0; a following restore leaves count_o=0.
REQ-038 Reset asserted mid-sequence at count 2 -> the next cycle shows all outputs 0; a pop immediately after reset has no effect.

Source files
------------

// File: rtl/cva6_ras_circ_pkg.sv
// Shared RAS types: core configuration, entry/snapshot records and the
// decoded operation kind for the circular return-address stack.
package ras_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned RASDepth;
    } cva6_cfg_t;

    localparam cva6_cfg_t CVA6Cfg = '{XLEN: 64, RASDepth: 2};

    localparam int unsigned RAS_PTR_W = $clog2(CVA6Cfg.RASDepth);

    typedef struct packed {
        logic [CVA6Cfg.XLEN-1:0] ra;
    } ras_entry_t;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] tos;
        logic [RAS_PTR_W:0]   count;
    } ras_ckpt_t;

    typedef enum logic [1:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPLACE
    } ras_op_e;

    function automatic bit ras_depth_legal(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/cva6_ras_circ_if.sv
// Call/return/checkpoint request bundle and stack-top view of the RAS.
interface cva6_ras_circ_if #(
    parameter int unsigned XLEN  = ras_pkg::CVA6Cfg.XLEN,
    parameter int unsigned DEPTH = ras_pkg::CVA6Cfg.RASDepth
);

    logic                   flush_i;
    logic                   push_i;
    logic [XLEN-1:0]        push_addr_i;
    logic                   pop_i;
    logic                   ckpt_save_i;
    logic                   ckpt_restore_i;
    logic                   top_valid_o;
    logic [XLEN-1:0]        top_addr_o;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        output flush_i, push_i, push_addr_i, pop_i, ckpt_save_i, ckpt_restore_i,
        input  top_valid_o, top_addr_o, count_o
    );

    modport slave (
        input  flush_i, push_i, push_addr_i, pop_i, ckpt_save_i, ckpt_restore_i,
        output top_valid_o, top_addr_o, count_o
    );

endinterface

// File: rtl/cva6_ras_circ.sv
// Circular return-address stack with saturating occupancy and a single
// tos/count checkpoint for mispredict recovery.
module cva6_ras_circ
    import ras_pkg::*;
#(
    parameter int unsigned XLEN    = CVA6Cfg.XLEN,
    parameter int unsigned DEPTH   = CVA6Cfg.RASDepth,
    parameter bit          CKPT_EN = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    cva6_ras_circ_if.slave ras
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    if (!ras_depth_legal(DEPTH)) begin : g_depth_check
        $error("cva6_ras_circ: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [XLEN-1:0] ra;
    } entry_t;

    typedef struct packed {
        logic [PTR_W-1:0] tos;
        logic [CNT_W-1:0] count;
    } ckpt_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W-1:0] tos_nxt;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    ckpt_t            ckpt;
    ras_op_e          op;
    logic             wr_en;
    logic             save_en;
    logic             restore_en;
    logic             top_valid;

    assign save_en    = CKPT_EN && ras.ckpt_save_i;
    assign restore_en = CKPT_EN && ras.ckpt_restore_i;

    always_comb begin
        op = RAS_IDLE;
        unique case ({ras.push_i, ras.pop_i})
            2'b10:   op = RAS_PUSH;
            2'b01:   op = RAS_POP;
            2'b11:   op = RAS_REPLACE;
            default: op = RAS_IDLE;
        endcase
    end

    always_comb begin
        tos_nxt   = tos;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = tos;
        unique case (op)
            RAS_PUSH: begin
                // Pointer wraps naturally; at saturation the oldest slot is reused.
                tos_nxt   = tos + 1'b1;
                wr_en     = 1'b1;
                wr_idx    = tos + 1'b1;
                count_nxt = (count == FULL) ? count : count + 1'b1;
            end
            RAS_POP: begin
                if (count != '0) begin
                    tos_nxt   = tos - 1'b1;
                    count_nxt = count - 1'b1;
                end
            end
            RAS_REPLACE: begin
                wr_en = 1'b1;
                if (count == '0) begin
                    count_nxt = CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos   <= '0;
            count <= '0;
            ckpt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ras.flush_i) begin
            tos   <= '0;
            count <= '0;
            ckpt  <= '0;
        end else if (restore_en) begin
            tos   <= ckpt.tos;
            count <= ckpt.count;
        end else begin
            tos   <= tos_nxt;
            count <= count_nxt;
            if (wr_en) begin
                mem[wr_idx].ra <= ras.push_addr_i;
            end
            // Snapshot holds the state as it will be after this cycle's update.
            if (save_en) begin
                ckpt <= '{tos: tos_nxt, count: count_nxt};
            end
        end
    end

    assign top_valid       = (count != '0);
    assign ras.top_valid_o = top_valid;
    assign ras.top_addr_o  = top_valid ? mem[tos].ra : '0;
    assign ras.count_o     = count;

endmodule
